// File: rtl/ax_btb_update_sender_pkg.sv
// Shared fetch-unit types for the AX BTB write path: branch results, BTB entry layout,
// the update-queue entry and the bank-conflict rule used by the update sender.
package ax_btb_update_sender_pkg;

    localparam int INT_ISSUE_WIDTH            = 2;
    localparam int ADDR_WIDTH                 = 32;
    localparam int INSN_ADDR_BIT_WIDTH        = 2;
    localparam int AX_BTB_INDEX_WIDTH         = 6;
    localparam int AX_BTB_TAG_WIDTH           = 8;
    localparam int BTB_CONTENTS_ADDR_WIDTH    = 14;
    localparam int AX_BTB_BANK_NUM            = 2;
    localparam int AX_BTB_UPDATE_QUEUE_DEPTH  = 8;

    typedef logic [ADDR_WIDTH-1:0]              AddrPath;
    typedef logic [AX_BTB_INDEX_WIDTH-1:0]      BTB_IndexPath;
    typedef logic [AX_BTB_TAG_WIDTH-1:0]        BTB_TagPath;
    typedef logic [BTB_CONTENTS_ADDR_WIDTH-1:0] BTB_AddrPath;
    typedef logic [$clog2(AX_BTB_UPDATE_QUEUE_DEPTH)-1:0] AXBTBUpdatePtrPath;
    typedef logic [$clog2(AX_BTB_UPDATE_QUEUE_DEPTH):0]   AXBTBUpdateCountPath;

    typedef struct packed {
        logic    valid;
        logic    execTaken;
        logic    isAX;
        logic    isCondBr;
        AddrPath brAddr;
        AddrPath nextAddr;
    } BranchResult;

    typedef struct packed {
        logic        valid;
        logic        isCondBr;
        BTB_TagPath  tag;
        BTB_AddrPath data;
    } BTB_Entry;

    typedef struct packed {
        BTB_IndexPath wa;
        BTB_Entry     wv;
    } AXBTBUpdateEntry;

    function automatic BTB_IndexPath ToAXBTB_Index(AddrPath addr);
        return addr[INSN_ADDR_BIT_WIDTH +: AX_BTB_INDEX_WIDTH];
    endfunction

    function automatic BTB_TagPath ToAXBTB_Tag(AddrPath addr);
        return addr[INSN_ADDR_BIT_WIDTH+AX_BTB_INDEX_WIDTH +: AX_BTB_TAG_WIDTH];
    endfunction

    function automatic BTB_AddrPath ToBTB_Addr(AddrPath addr);
        return addr[INSN_ADDR_BIT_WIDTH +: BTB_CONTENTS_ADDR_WIDTH];
    endfunction

    // Bank is the low log2(bankNum) bits of the index; bankNum must be a power of two.
    function automatic logic IsBankConflict(BTB_IndexPath a, BTB_IndexPath b, int bankNum);
        BTB_IndexPath mask;
        mask = BTB_IndexPath'(bankNum - 1);
        return (a & mask) == (b & mask);
    endfunction

endpackage

// File: rtl/ax_btb_update_sender_queue.sv
// Multi-push / multi-pop circular buffer holding pending AX BTB writes in program order.
module ax_btb_update_queue
    import ax_btb_update_sender_pkg::*;
#(
    parameter int DEPTH    = AX_BTB_UPDATE_QUEUE_DEPTH,
    parameter int PUSH_NUM = INT_ISSUE_WIDTH,
    parameter int POP_NUM  = INT_ISSUE_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(DEPTH):0]  pushCount_i,
    input  AXBTBUpdateEntry         pushEntry_i [PUSH_NUM],
    input  logic [$clog2(DEPTH):0]  popCount_i,
    output AXBTBUpdateEntry         headEntry_o [POP_NUM],
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic [$clog2(DEPTH):0]  freeCount_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    AXBTBUpdateEntry    storage_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointer arithmetic wraps for free because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q + popCount_i[PTR_W-1:0];
        tail_d  = tail_q + pushCount_i[PTR_W-1:0];
        count_d = count_q + pushCount_i - popCount_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (CNT_W'(i) < pushCount_i) begin
                storage_q[tail_q + PTR_W'(i)] <= pushEntry_i[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < POP_NUM; i++) begin
            headEntry_o[i] = storage_q[head_q + PTR_W'(i)];
        end
    end

    assign occupancy_o = count_q;
    assign freeCount_o = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/ax_btb_update_sender.sv
// Buffers taken AX branch results and drains them to the AX BTB write ports in order,
// never sending two writes to the same bank in one cycle.
module ax_btb_update_sender
    import ax_btb_update_sender_pkg::*;
#(
    parameter int LANE_NUM       = INT_ISSUE_WIDTH,
    parameter int WRITE_PORT_NUM = INT_ISSUE_WIDTH,
    parameter int QUEUE_DEPTH    = AX_BTB_UPDATE_QUEUE_DEPTH,
    parameter int BANK_NUM       = AX_BTB_BANK_NUM
)(
    input  logic         clk,
    input  logic         rst,
    input  BranchResult  brResult_i [LANE_NUM],
    input  logic         btbStall_i,
    output logic         btbWE_o [WRITE_PORT_NUM],
    output BTB_IndexPath btbWA_o [WRITE_PORT_NUM],
    output BTB_Entry     btbWV_o [WRITE_PORT_NUM],
    output logic         queueFull_o,
    output logic [15:0]  dropCount_o
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    typedef logic [CNT_W-1:0] CountPath;

    CountPath        pushCount, popCount, freeCount, occupancy, dropThisCycle;
    AXBTBUpdateEntry pushEntry [LANE_NUM];
    AXBTBUpdateEntry headEntry [WRITE_PORT_NUM];
    logic            sel [WRITE_PORT_NUM];
    logic            selStop;
    logic            unusedLaneBits;
    logic [16:0]     dropSum;
    logic [15:0]     dropCount_q, dropCount_d;
    logic            btbWE_q [WRITE_PORT_NUM];
    BTB_IndexPath    btbWA_q [WRITE_PORT_NUM];
    BTB_Entry        btbWV_q [WRITE_PORT_NUM];

    ax_btb_update_queue #(
        .DEPTH    (QUEUE_DEPTH),
        .PUSH_NUM (LANE_NUM),
        .POP_NUM  (WRITE_PORT_NUM)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .pushCount_i (pushCount),
        .pushEntry_i (pushEntry),
        .popCount_i  (popCount),
        .headEntry_o (headEntry),
        .occupancy_o (occupancy),
        .freeCount_o (freeCount)
    );

    // Accepted lanes are compacted into push slots; free space is judged against the
    // current occupancy, so entries popped this cycle are not reusable until next cycle.
    always_comb begin
        pushCount      = '0;
        dropThisCycle  = '0;
        unusedLaneBits = 1'b0;
        for (int s = 0; s < LANE_NUM; s++) begin
            pushEntry[s] = '0;
        end
        for (int i = 0; i < LANE_NUM; i++) begin
            unusedLaneBits ^= ^brResult_i[i];
            if (brResult_i[i].valid && brResult_i[i].execTaken && brResult_i[i].isAX) begin
                if (pushCount < freeCount) begin
                    for (int s = 0; s < LANE_NUM; s++) begin
                        if (CountPath'(s) == pushCount) begin
                            pushEntry[s].wa          = ToAXBTB_Index(brResult_i[i].brAddr);
                            pushEntry[s].wv.valid    = 1'b1;
                            pushEntry[s].wv.isCondBr = brResult_i[i].isCondBr;
                            pushEntry[s].wv.tag      = ToAXBTB_Tag(brResult_i[i].brAddr);
                            pushEntry[s].wv.data     = ToBTB_Addr(brResult_i[i].nextAddr);
                        end
                    end
                    pushCount = pushCount + CountPath'(1);
                end else begin
                    dropThisCycle = dropThisCycle + CountPath'(1);
                end
            end
        end
    end

    always_comb begin
        dropSum     = {1'b0, dropCount_q} + 17'(dropThisCycle);
        dropCount_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end

    // In-order selection from the head: the first bank clash ends the window.
    always_comb begin
        selStop  = btbStall_i;
        popCount = '0;
        for (int p = 0; p < WRITE_PORT_NUM; p++) begin
            sel[p] = 1'b0;
            if (CountPath'(p) >= occupancy) begin
                selStop = 1'b1;
            end
            for (int k = 0; k < p; k++) begin
                if (IsBankConflict(headEntry[k].wa, headEntry[p].wa, BANK_NUM)) begin
                    selStop = 1'b1;
                end
            end
            if (!selStop) begin
                sel[p]   = 1'b1;
                popCount = popCount + CountPath'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCount_q <= '0;
            for (int p = 0; p < WRITE_PORT_NUM; p++) begin
                btbWE_q[p] <= 1'b0;
                btbWA_q[p] <= '0;
                btbWV_q[p] <= '0;
            end
        end else begin
            dropCount_q <= dropCount_d;
            for (int p = 0; p < WRITE_PORT_NUM; p++) begin
                btbWE_q[p] <= sel[p];
                if (sel[p]) begin
                    btbWA_q[p] <= headEntry[p].wa;
                    btbWV_q[p] <= headEntry[p].wv;
                end
            end
        end
    end

    assign btbWE_o     = btbWE_q;
    assign btbWA_o     = btbWA_q;
    assign btbWV_o     = btbWV_q;
    assign queueFull_o = (occupancy == CountPath'(QUEUE_DEPTH));
    assign dropCount_o = dropCount_q;

endmodule

// File: tb/tb_ax_btb_update_sender.sv
// Self-checking bench for ax_btb_update_sender: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based reference model.
module tb_ax_btb_update_sender;
    import ax_btb_update_sender_pkg::*;

    localparam int LANE  = 2;
    localparam int WPN   = 2;
    localparam int DEPTH = 8;
    localparam int BANKS = 2;

    logic         clk;
    logic         rst;
    BranchResult  brResult [LANE];
    logic         btbStall;
    logic         btbWE [WPN];
    BTB_IndexPath btbWA [WPN];
    BTB_Entry     btbWV [WPN];
    logic         queueFull;
    logic [15:0]  dropCount;

    AXBTBUpdateEntry mq[$];
    int              mDrop;
    logic            expWE [WPN];
    BTB_IndexPath    expWA [WPN];
    BTB_Entry        expWV [WPN];

    int checkCount;
    int passCount;

    ax_btb_update_sender dut (
        .clk         (clk),
        .rst         (rst),
        .brResult_i  (brResult),
        .btbStall_i  (btbStall),
        .btbWE_o     (btbWE),
        .btbWA_o     (btbWA),
        .btbWV_o     (btbWV),
        .queueFull_o (queueFull),
        .dropCount_o (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic AXBTBUpdateEntry makeEntry(BranchResult r);
        AXBTBUpdateEntry e;
        e.wa          = BTB_IndexPath'((r.brAddr >> 2) % 64);
        e.wv.valid    = 1'b1;
        e.wv.isCondBr = r.isCondBr;
        e.wv.tag      = BTB_TagPath'((r.brAddr >> 8) % 256);
        e.wv.data     = BTB_AddrPath'((r.nextAddr >> 2) % 16384);
        return e;
    endfunction

    task automatic setLane(int l, logic v, logic t, logic ax, logic cb, logic [31:0] a, logic [31:0] n);
        brResult[l].valid     = v;
        brResult[l].execTaken = t;
        brResult[l].isAX      = ax;
        brResult[l].isCondBr  = cb;
        brResult[l].brAddr    = a;
        brResult[l].nextAddr  = n;
    endtask

    task automatic clearLanes();
        for (int l = 0; l < LANE; l++) setLane(l, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic modelReset();
        mq.delete();
        mDrop = 0;
        for (int p = 0; p < WPN; p++) expWE[p] = 1'b0;
    endtask

    // Advance one edge; the model selects from its pre-edge queue, then accepts inputs.
    task automatic stepClock();
        int  occBefore;
        int  nSel;
        int  accepted;
        logic clash;
        @(posedge clk);
        occBefore = mq.size();
        nSel = 0;
        for (int p = 0; p < WPN; p++) expWE[p] = 1'b0;
        if (!btbStall) begin
            for (int p = 0; p < WPN; p++) begin
                if (p >= occBefore) break;
                clash = 1'b0;
                for (int k = 0; k < p; k++)
                    if ((mq[k].wa % BANKS) == (mq[p].wa % BANKS)) clash = 1'b1;
                if (clash) break;
                expWE[p] = 1'b1;
                expWA[p] = mq[p].wa;
                expWV[p] = mq[p].wv;
                nSel++;
            end
        end
        repeat (nSel) void'(mq.pop_front());
        accepted = 0;
        for (int l = 0; l < LANE; l++) begin
            if (brResult[l].valid && brResult[l].execTaken && brResult[l].isAX) begin
                if (accepted < DEPTH - occBefore) begin
                    mq.push_back(makeEntry(brResult[l]));
                    accepted++;
                end else if (mDrop < 65535) begin
                    mDrop++;
                end
            end
        end
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #2;
        modelReset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int p = 0; p < WPN; p++) begin
            checkCount++;
            if (btbWE[p] !== 1'b0) $display("[TB] FAIL reset_we%0d: got %0b want 0", p, btbWE[p]);
            else passCount++;
            checkCount++;
            if (btbWA[p] !== '0 || btbWV[p] !== '0)
                $display("[TB] FAIL reset_wa_wv%0d: got %h/%h want 0/0", p, btbWA[p], btbWV[p]);
            else passCount++;
        end
        checkCount++;
        if (queueFull !== 1'b0 || dropCount !== 16'd0)
            $display("[TB] FAIL reset_full_drop: got %0b/%0d want 0/0", queueFull, dropCount);
        else passCount++;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_single();
        setLane(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 32'h2000);
        stepClock();
        clearLanes();
        checkCount++;
        if (btbWE[0] !== 1'b0) $display("[TB] FAIL single_early: got %0b want 0", btbWE[0]);
        else passCount++;
        stepClock();
        checkCount++;
        if (btbWE[0] !== 1'b1 || btbWE[1] !== 1'b0)
            $display("[TB] FAIL single_we: got %0b%0b want 10", btbWE[0], btbWE[1]);
        else passCount++;
        checkCount++;
        if (btbWA[0] !== 6'h00 || btbWV[0] !== {1'b1, 1'b1, 8'h10, 14'h0800})
            $display("[TB] FAIL single_data: got %h/%h want 00/%h", btbWA[0], btbWV[0],
                     {1'b1, 1'b1, 8'h10, 14'h0800});
        else passCount++;
        stepClock();
        checkCount++;
        if (btbWE[0] !== 1'b0) $display("[TB] FAIL single_once: got %0b want 0", btbWE[0]);
        else passCount++;
    endtask

    task automatic test_same_bank();
        setLane(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h3000);
        setLane(1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1008, 32'h3004);
        stepClock();
        clearLanes();
        stepClock();
        checkCount++;
        if (btbWE[0] !== 1'b1 || btbWE[1] !== 1'b0 || btbWA[0] !== 6'd0)
            $display("[TB] FAIL samebank_t2: got we=%0b%0b wa=%0d want we=10 wa=0", btbWE[0], btbWE[1], btbWA[0]);
        else passCount++;
        stepClock();
        checkCount++;
        if (btbWE[0] !== 1'b1 || btbWE[1] !== 1'b0 || btbWA[0] !== 6'd2)
            $display("[TB] FAIL samebank_t3: got we=%0b%0b wa=%0d want we=10 wa=2", btbWE[0], btbWE[1], btbWA[0]);
        else passCount++;
        stepClock();
    endtask

    task automatic test_diff_bank();
        setLane(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 32'h5000);
        setLane(1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1004, 32'h6000);
        stepClock();
        clearLanes();
        stepClock();
        checkCount++;
        if (btbWE[0] !== 1'b1 || btbWE[1] !== 1'b1 || btbWA[0] !== 6'd0 || btbWA[1] !== 6'd1)
            $display("[TB] FAIL diffbank: got we=%0b%0b wa=%0d,%0d want we=11 wa=0,1",
                     btbWE[0], btbWE[1], btbWA[0], btbWA[1]);
        else passCount++;
        stepClock();
    endtask

    task automatic test_stall_overflow();
        int got[$];
        applyReset();
        btbStall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int l = 0; l < LANE; l++)
                setLane(l, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4000 + 32'((2 * c + l) * 4), 32'h8000 + 32'(c * 16));
            stepClock();
        end
        clearLanes();
        checkCount++;
        if (queueFull !== 1'b1 || dropCount !== 16'd2 || btbWE[0] !== 1'b0)
            $display("[TB] FAIL overflow: got full=%0b drop=%0d we0=%0b want 1/2/0", queueFull, dropCount, btbWE[0]);
        else passCount++;
        btbStall = 1'b0;
        for (int c = 0; c < 6; c++) begin
            stepClock();
            for (int p = 0; p < WPN; p++) if (btbWE[p] === 1'b1) got.push_back(int'(btbWA[p]));
        end
        checkCount++;
        if (got.size() != 8) $display("[TB] FAIL drain_count: got %0d want 8", got.size());
        else passCount++;
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checkCount++;
            if (got[i] != i) $display("[TB] FAIL drain_order%0d: got %0d want %0d", i, got[i], i);
            else passCount++;
        end
        checkCount++;
        if (queueFull !== 1'b0 || mq.size() != 0)
            $display("[TB] FAIL drain_empty: got full=%0b model=%0d want 0/0", queueFull, mq.size());
        else passCount++;
    endtask

    task automatic test_filtering();
        int weSeen;
        int dropBefore;
        int which;
        weSeen = 0;
        dropBefore = mDrop;
        for (int c = 0; c < 20; c++) begin
            for (int l = 0; l < LANE; l++) begin
                which = $urandom_range(0, 2);
                setLane(l, which != 0, which != 1, which != 2, 1'($urandom), $urandom, $urandom);
            end
            stepClock();
            for (int p = 0; p < WPN; p++) if (btbWE[p] !== 1'b0) weSeen++;
        end
        clearLanes();
        stepClock();
        checkCount++;
        if (weSeen != 0) $display("[TB] FAIL filter_we: got %0d writes want 0", weSeen);
        else passCount++;
        checkCount++;
        if (dropCount !== 16'(dropBefore))
            $display("[TB] FAIL filter_drop: got %0d want %0d", dropCount, dropBefore);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int weSeen;
        btbStall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int l = 0; l < LANE; l++)
                setLane(l, 1'b1, 1'b1, 1'b1, 1'b1, 32'h9000 + 32'((2 * c + l) * 4), 32'hA000);
            stepClock();
        end
        clearLanes();
        btbStall = 1'b0;
        stepClock();
        checkCount++;
        if (btbWE[0] !== 1'b1) $display("[TB] FAIL resetmid_pre: got %0b want 1", btbWE[0]);
        else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if (btbWE[0] !== 1'b0 || btbWE[1] !== 1'b0)
            $display("[TB] FAIL resetmid_async: got %0b%0b want 00", btbWE[0], btbWE[1]);
        else passCount++;
        modelReset();
        rst = 1'b0;
        weSeen = 0;
        for (int c = 0; c < 5; c++) begin
            stepClock();
            for (int p = 0; p < WPN; p++) if (btbWE[p] !== 1'b0) weSeen++;
        end
        checkCount++;
        if (weSeen != 0 || queueFull !== 1'b0)
            $display("[TB] FAIL resetmid_after: got writes=%0d full=%0b want 0/0", weSeen, queueFull);
        else passCount++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            btbStall = ($urandom_range(0, 9) < 4);
            for (int l = 0; l < LANE; l++)
                setLane(l, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        1'($urandom), $urandom, $urandom);
            stepClock();
            for (int p = 0; p < WPN; p++) begin
                checkCount++;
                if (btbWE[p] !== expWE[p])
                    $display("[TB] FAIL rand_we%0d cyc%0d: got %0b want %0b", p, c, btbWE[p], expWE[p]);
                else passCount++;
                if (expWE[p]) begin
                    checkCount++;
                    if (btbWA[p] !== expWA[p] || btbWV[p] !== expWV[p])
                        $display("[TB] FAIL rand_data%0d cyc%0d: got %h/%h want %h/%h",
                                 p, c, btbWA[p], btbWV[p], expWA[p], expWV[p]);
                    else passCount++;
                end
            end
            checkCount++;
            if (queueFull !== (mq.size() == DEPTH) || dropCount !== 16'(mDrop))
                $display("[TB] FAIL rand_status cyc%0d: got full=%0b drop=%0d want %0b/%0d",
                         c, queueFull, dropCount, mq.size() == DEPTH, mDrop);
            else passCount++;
        end
        btbStall = 1'b0;
        clearLanes();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        btbStall   = 1'b0;
        clearLanes();
        modelReset();
        test_reset();
        test_single();
        test_same_bank();
        test_diff_bank();
        test_stall_overflow();
        test_filtering();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ax_btb_update_sender.md
# ax_btb_update_sender

Transmit-side counterpart of the approximate-branch BTB write interface. It collects resolved approximate (AX) branch outcomes from the integer execution lanes and buffers the taken ones in an in-order queue. It drains them onto the AX BTB write ports at up to `WRITE_PORT_NUM` per cycle, never issuing two writes to the same bank in one cycle. It sits between the IntEx stage and the AX BTB, so the BTB needs no conflict-overflow queue of its own.

## Interface
Parameters:
- `LANE_NUM`, default `INT_ISSUE_WIDTH` (2): number of execution lanes delivering results.
- `WRITE_PORT_NUM`, default `INT_ISSUE_WIDTH` (2): number of BTB write ports driven.
- `QUEUE_DEPTH`, default 8: buffer entries; power of two, at least `LANE_NUM`.
- `BANK_NUM`, default 2: BTB banks; bank = low `log2(BANK_NUM)` bits of the BTB index.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `brResult[LANE_NUM]`, in, `BranchResult`: per-lane `valid`, `execTaken`, `isAX`, `isCondBr`, `brAddr`, `nextAddr`.
- `btbStall`, in, 1: BTB is busy (e.g. in its reset sequence); suppresses issue.
- `btbWE[WRITE_PORT_NUM]`, out, 1: write enable, registered.
- `btbWA[WRITE_PORT_NUM]`, out, `BTB_IndexPath`: write index, from `ToAXBTB_Index(brAddr)`.
- `btbWV[WRITE_PORT_NUM]`, out, `BTB_Entry`: tag = `ToAXBTB_Tag(brAddr)`, data = `ToBTB_Addr(nextAddr)`, `valid` = 1, `isCondBr`.
- `queueFull`, out, 1: occupancy == `QUEUE_DEPTH`.
- `dropCount`, out, 16: saturating count of qualifying results discarded because the queue was full.

## Operation
- **Qualifying result:** `valid && execTaken && isAX`. Every other lane input is ignored.
- **Enqueue:**
  - Qualifying lanes are enqueued in ascending lane order, lane 0 first.
  - If free entries are fewer than the number of qualifying lanes, only the lowest-numbered lanes that fit are accepted.
  - Each rejected result increments `dropCount` by 1; the count saturates at 0xFFFF.
  - AX targets are hints, so dropping is legal. There is no backpressure to the execution lanes.
- **Dequeue selection** (combinational, from the registered queue state):
  - Walk entries from the head in order, up to `min(WRITE_PORT_NUM, occupancy)`.
  - Stop at the first entry whose bank equals the bank of an entry already selected in this cycle. Entries are never reordered.
  - Selected entries map to write ports 0, 1, … in queue order. They are popped and registered into `btbWE/btbWA/btbWV` at the same edge.
  - When `btbStall` = 1, nothing is selected and `btbWE` is all 0 in the next cycle.
- **Ordering:** two results to the same index always land in different cycles, because a same-index pair is also a same-bank pair. The younger result is written last.
- **Simultaneous push and pop:** allowed in the same cycle. Occupancy update: `occ_next = occ + pushed − popped`. The freed space is not reusable until the next cycle; the free-count check uses the current `occ`.
- **Pointers:** `log2(QUEUE_DEPTH)` bits wide, wrap modulo the depth. Occupancy is `log2(QUEUE_DEPTH)+1` bits wide.

## Timing
- **Reset values:** head, tail and occupancy = 0; `btbWE` all 0; `btbWA`/`btbWV` = 0; `queueFull` = 0; `dropCount` = 0.
- **Reset mid-operation:** the queue is discarded and `btbWE` deasserts immediately (asynchronous).
- **Minimum latency:** a result sampled at edge E0 drives `btbWE` high in the cycle after edge E1 (2 edges).
- **Throughput:** `WRITE_PORT_NUM` writes per cycle when head entries hit distinct banks; 1 per cycle when consecutive entries share a bank.
- **`queueFull`:** reflects registered occupancy, so it updates one edge after the push.
- **`btbStall` rising:** takes effect on the next registered output; entries stay queued.

## Structure
- **Package additions to `FetchUnitTypes`:**
  - `AXBTBUpdateEntry` struct: `wa`, `wv`.
  - `AX_BTB_UPDATE_QUEUE_DEPTH`.
  - `AXBTBUpdatePtrPath` and `AXBTBUpdateCountPath` types.
  - A shared `IsBankConflict` function.
- **Sub-module `ax_btb_update_queue`:** multi-push / multi-pop circular buffer.
  - Storage array, head/tail pointers and occupancy.
  - Inputs: `pushCount`, `popCount`.
  - Outputs: head window of `WRITE_PORT_NUM` entries, `freeCount`.
- **Top level:** qualification, drop accounting, bank-conflict selection and the output register.

## Test plan
- **Single result:** lane 0 gets a qualifying result, `brAddr` = 0x1000, `nextAddr` = 0x2000 → two edges later `btbWE[0]` = 1 for one cycle with `btbWA` = index(0x1000) and data = `ToBTB_Addr(0x2000)`; `btbWE[1]` = 0.
- **Same-bank pair:** both lanes qualify in one cycle on the same bank → lane 0 is written on port 0 in cycle t+2, lane 1 on port 0 in cycle t+3.
- **Different-bank pair:** both lanes qualify on different banks → `btbWE[0]` and `btbWE[1]` both 1 in the same cycle.
- **Stall and overflow:**
  - Hold `btbStall` = 1 and send 5 cycles of 2 qualifying results: 8 are accepted, `queueFull` = 1, `dropCount` = 2.
  - Release `btbStall`: the queue drains in order, 8 writes, occupancy returns to 0.
- **Filtering:** non-taken, non-AX and invalid results → `btbWE` never asserts; `dropCount` unchanged.
- **Reset mid-operation:** assert `rst` asynchronously with 4 queued entries → `btbWE` = 0 immediately; after release there are no writes until new input arrives.
